prim_ray_dispatch: RTL and testbench
====================================

Name: prim_ray_dispatch

Overview:
- Sits between the primary ray generator and the intersection unit.
- Accepts primary rays from the generator's output FIFO and tags each with a ray ID taken from a free-ID pool. Records the pixel index that owns each ID and forwards the tagged ray to intersection.
- On ray retirement from the shader, returns the pixel index and recycles the ID.
- Raises frame_done once every pixel has been issued and retired.

Parameters:
RAY_W, 211, width of the primary ray payload
NUM_IDS, 16, number of ray IDs in flight; power of 2
ID_W, 4, log2(NUM_IDS)
SCR_W, 640, screen width in pixels
SCR_H, 480, screen height in pixels
PIX_W, 19, pixel index width; must hold SCR_W*SCR_H-1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins next frame from DONE
prg_to_int_valid  in  1  upstream ray available
prg_data  in  RAY_W  upstream ray payload
prg_to_int_stall  out  1  backpressure to upstream
int_valid  out  1  tagged ray valid to intersection
int_id  out  ID_W  ray ID of int_data
int_data  out  RAY_W  ray payload to intersection
int_stall  in  1  backpressure from intersection
ret_valid  in  1  ray retired (one-cycle pulse)
ret_id  in  ID_W  ID of retired ray
pix_valid  out  1  pixel index valid (one-cycle pulse)
pix_idx  out  PIX_W  pixel index owning the retired ID
frame_done  out  1  frame complete; level
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: int_valid=0, int_id=0, int_data=0, pix_valid=0, pix_idx=0, frame_done=0, err=0, prg_to_int_stall=1.
- Outstanding counter is $clog2(NUM_IDS+1) bits wide. Issued counter is PIX_W bits wide.
- State machine: INIT, RUN, DRAIN, DONE.
  - Reset enters INIT. INIT pushes IDs 0..NUM_IDS-1 into the free FIFO, one per cycle. It then enters RUN; INIT lasts exactly NUM_IDS cycles after reset release.
  - RUN: accepts rays. After accepting pixel index SCR_W*SCR_H-1, moves to DRAIN.
  - DRAIN: when the outstanding count reaches 0 (including a retire in the same cycle), moves to DONE the next cycle.
  - DONE: frame_done=1. A start pulse clears frame_done, clears the issued counter, and enters RUN. start in any other state is ignored.
- Stall and accept:
  - prg_to_int_stall = (state!=RUN) | free_empty | (int_valid & int_stall).
  - Accept occurs when prg_to_int_valid=1 and prg_to_int_stall=0.
- On accept:
  - Pop the free FIFO head as the new ID; write pix_table[ID] = issued count; increment issued and outstanding.
  - Load the output register next edge: int_valid=1, int_id=ID, int_data=prg_data. Latency is 1 cycle.
- Output register:
  - Holds int_id/int_data stable while int_valid & int_stall.
  - Clears int_valid when consumed (int_stall=0) with no new accept.
  - Back-to-back accepts give one ray per cycle.
- Retire:
  - ret_valid pushes ret_id to the free FIFO tail and decrements outstanding.
  - The next cycle it drives pix_valid=1 and pix_idx=pix_table[ret_id].
  - pix has no backpressure.
- Same-cycle allocate and retire: both occur and outstanding is unchanged.
  - No bypass: a retired ID is not allocatable in the same cycle.
  - Freed IDs are reallocated in FIFO order.
- Free list full can never occur with legal retires. A push when full is dropped and sets err in check builds.
- Pixel index is arrival order: 0 for the first ray of the frame, incrementing to SCR_W*SCR_H-1.
- Reset mid-frame: all state is discarded, including outstanding rays. The block returns to INIT.

Optional Feature:
Macro PRIM_RAY_DISPATCH_CHECK_EN.
- Defined:
  - Keeps an NUM_IDS-bit outstanding bitmap: set on allocate, cleared on retire.
  - err is set and stays set until reset on any of:
    - retire of an ID whose bit is clear;
    - ret_valid in INIT or DONE;
    - prg_to_int_valid dropping while stalled and holding.
  - The bitmap is ignored for flow control.
- Undefined: no bitmap; err tied to 0.

Test Plan:
- Reset release, prg_to_int_valid=1 throughout -> stall=1 for exactly 16 cycles; first accept on cycle 17; int_valid=1 with int_id=0 the following cycle.
- 16 accepts, no retires, int_stall=0 -> int_id sequence 0..15; stall=1 on the 17th ray and held indefinitely.
- From the full state, ret_valid with ret_id=5 after ray index 5 was issued -> pix_valid=1, pix_idx=5 next cycle; the next accepted ray gets int_id=5, pixel index 16.
- int_stall=1 for 4 cycles with int_valid=1 -> int_id/int_data unchanged, stall=1, no accepts; release -> accepts resume the next cycle.
- SCR_W=4, SCR_H=2, retire every ID 3 cycles after issue -> 8 rays issued, stall=1 after the 8th; frame_done=1 the cycle after the last retire; start -> frame_done=0, next ray pixel index 0.
- CHECK_EN defined: retire ID 3 twice -> err=1 after the second retire and stays high; undefined -> err=0.

Source files
------------

// File: rtl/prim_ray_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prim_ray_dispatch                                               |
// | Tags primary rays with IDs from a free-ID pool and returns the owning      |
// | pixel on retire. Optional checker macro: PRIM_RAY_DISPATCH_CHECK_EN.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module prim_ray_dispatch #(
    parameter int RAY_W   = 211,
    parameter int NUM_IDS = 16,
    parameter int ID_W    = 4,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int PIX_W   = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             prg_to_int_valid,
    input  logic [RAY_W-1:0] prg_data,
    output logic             prg_to_int_stall,
    output logic             int_valid,
    output logic [ID_W-1:0]  int_id,
    output logic [RAY_W-1:0] int_data,
    input  logic             int_stall,
    input  logic             ret_valid,
    input  logic [ID_W-1:0]  ret_id,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_idx,
    output logic             frame_done,
    output logic             err
);
    localparam int               CNT_W    = $clog2(NUM_IDS + 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(SCR_W * SCR_H - 1);
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  init_cnt_q, init_cnt_d;
    logic [ID_W-1:0]  free_mem_q [NUM_IDS];
    logic [PIX_W-1:0] pix_table_q [NUM_IDS];
    logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [PIX_W-1:0] issued_q, issued_d;
    logic             int_valid_q, int_valid_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic [RAY_W-1:0] int_data_q, int_data_d;
    logic             pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;

    logic             free_empty, free_full, accept, ret_live, ret_dec, push_en;
    logic [ID_W-1:0]  push_id, alloc_id;

    always_comb begin
        free_empty       = (free_cnt_q == '0);
        free_full        = (free_cnt_q == CNT_W'(NUM_IDS));
        prg_to_int_stall = (state_q != ST_RUN) | free_empty | (int_valid_q & int_stall);
        accept           = prg_to_int_valid & ~prg_to_int_stall;
        alloc_id         = free_mem_q[head_q];
        // Retires during INIT are illegal; the init sequence owns the push port then.
        ret_live         = ret_valid & (state_q != ST_INIT);
        ret_dec          = ret_live & (outst_q != '0);
        push_en          = (state_q == ST_INIT) | (ret_live & ~free_full);
        push_id          = (state_q == ST_INIT) ? init_cnt_q : ret_id;

        head_d     = head_q + ID_W'(accept);
        tail_d     = tail_q + ID_W'(push_en);
        free_cnt_d = free_cnt_q + CNT_W'(push_en) - CNT_W'(accept);
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(ret_dec);

        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        issued_d   = accept ? issued_q + PIX_W'(1) : issued_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ID_W'(1);
                if (init_cnt_q == ID_W'(NUM_IDS - 1)) state_d = ST_RUN;
            end
            ST_RUN:   if (accept && issued_q == LAST_PIX) state_d = ST_DRAIN;
            ST_DRAIN: if (outst_d == '0) state_d = ST_DONE;
            ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    issued_d = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase

        int_valid_d = int_valid_q;
        int_id_d    = int_id_q;
        int_data_d  = int_data_q;
        if (accept) begin
            int_valid_d = 1'b1;
            int_id_d    = alloc_id;
            int_data_d  = prg_data;
        end else if (!int_stall) begin
            int_valid_d = 1'b0;
        end

        pix_valid_d = ret_valid;
        pix_idx_d   = ret_valid ? pix_table_q[ret_id] : pix_idx_q;
    end

    always_ff @(posedge clk) begin
        if (push_en) free_mem_q[tail_q]    <= push_id;
        if (accept)  pix_table_q[alloc_id] <= issued_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            free_cnt_q  <= '0;
            outst_q     <= '0;
            issued_q    <= '0;
            int_valid_q <= 1'b0;
            int_id_q    <= '0;
            int_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            free_cnt_q  <= free_cnt_d;
            outst_q     <= outst_d;
            issued_q    <= issued_d;
            int_valid_q <= int_valid_d;
            int_id_q    <= int_id_d;
            int_data_q  <= int_data_d;
            pix_valid_q <= pix_valid_d;
            pix_idx_q   <= pix_idx_d;
        end
    end

    assign int_valid  = int_valid_q;
    assign int_id     = int_id_q;
    assign int_data   = int_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_idx    = pix_idx_q;
    assign frame_done = (state_q == ST_DONE);

`ifdef PRIM_RAY_DISPATCH_CHECK_EN
    logic [NUM_IDS-1:0] bitmap_q, bitmap_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;

    always_comb begin
        bitmap_d = bitmap_q;
        if (accept)    bitmap_d[alloc_id] = 1'b1;
        if (ret_valid) bitmap_d[ret_id]   = 1'b0;
        hold_d = prg_to_int_valid & prg_to_int_stall;
        err_d  = err_q
               | (ret_valid & ~bitmap_q[ret_id])
               | (ret_valid & ((state_q == ST_INIT) | (state_q == ST_DONE)))
               | (hold_q & ~prg_to_int_valid)
               | (ret_live & free_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitmap_q <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prim_ray_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prim_ray_dispatch                                            |
// | Scoreboard bench for prim_ray_dispatch on an 8x4 screen with 16 IDs.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_prim_ray_dispatch;
    localparam int RAY_W   = 32;
    localparam int NUM_IDS = 16;
    localparam int ID_W    = 4;
    localparam int SCR_W   = 8;
    localparam int SCR_H   = 4;
    localparam int PIX_W   = 5;
    localparam int NPIX    = SCR_W * SCR_H;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             prg_to_int_valid = 1'b0;
    logic [RAY_W-1:0] prg_data = '0;
    logic             int_stall = 1'b0;
    logic             ret_valid = 1'b0;
    logic [ID_W-1:0]  ret_id = '0;
    logic             prg_to_int_stall, int_valid, pix_valid, frame_done, err;
    logic [ID_W-1:0]  int_id;
    logic [RAY_W-1:0] int_data;
    logic [PIX_W-1:0] pix_idx;

    always #5 clk = ~clk;

    prim_ray_dispatch #(
        .RAY_W(RAY_W), .NUM_IDS(NUM_IDS), .ID_W(ID_W),
        .SCR_W(SCR_W), .SCR_H(SCR_H), .PIX_W(PIX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .prg_to_int_valid(prg_to_int_valid), .prg_data(prg_data),
        .prg_to_int_stall(prg_to_int_stall),
        .int_valid(int_valid), .int_id(int_id), .int_data(int_data),
        .int_stall(int_stall),
        .ret_valid(ret_valid), .ret_id(ret_id),
        .pix_valid(pix_valid), .pix_idx(pix_idx),
        .frame_done(frame_done), .err(err)
    );

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [RAY_W-1:0] data;
    } int_t;

    int_t             exp_int[$];
    logic [PIX_W-1:0] exp_pix[$];
    int               free_q[$];
    int               out_q[$];
    int               pix_tab[NUM_IDS];
    int               m_state, m_init, m_outst, m_issued, last_acc_id, seq;
    bit               m_intv;
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the reference model advances with the same edge.
    task automatic cyc(input bit v, input bit ist, input bit st, input bit rv, input int rid);
        bit   exp_stall, acc, full_before;
        int   id;
        int_t e;
        prg_to_int_valid = v;
        int_stall        = ist;
        start            = st;
        ret_valid        = rv;
        ret_id           = rid[ID_W-1:0];
        seq++;
        prg_data         = 32'hC0DE_0000 + seq;
        @(negedge clk);
        exp_stall = (m_state != 1) || (free_q.size() == 0) || (m_intv && ist);
        chk("stall", prg_to_int_stall, exp_stall);
        chk("int_valid", int_valid, m_intv);
        chk("frame_done", frame_done, m_state == 3);
`ifndef PRIM_RAY_DISPATCH_CHECK_EN
        chk("err_off", err, 0);
`endif
        full_before = (free_q.size() == NUM_IDS);
        acc = v && !exp_stall;
        if (acc) begin
            id          = free_q.pop_front();
            pix_tab[id] = m_issued;
            e.id        = id[ID_W-1:0];
            e.data      = prg_data;
            exp_int.push_back(e);
            out_q.push_back(id);
            last_acc_id = id;
            m_issued++;
            m_outst++;
        end
        if (rv) begin
            exp_pix.push_back(PIX_W'(pix_tab[rid]));
            for (int i = 0; i < out_q.size(); i++)
                if (out_q[i] == rid) begin
                    out_q.delete(i);
                    break;
                end
            if (m_state != 0) begin
                if (!full_before) free_q.push_back(rid);
                if (m_outst > 0) m_outst--;
            end
        end
        m_intv = acc || (m_intv && ist);
        case (m_state)
            0: begin
                free_q.push_back(m_init);
                m_init++;
                if (m_init == NUM_IDS) m_state = 1;
            end
            1: if (acc && m_issued == NPIX) m_state = 2;
            2: if (m_outst == 0) m_state = 3;
            default: if (st) begin
                m_state  = 1;
                m_issued = 0;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            if (int_valid) begin
                if (exp_int.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL int_unexpected: got id %0d with nothing expected", int_id);
                end else begin
                    chk("int_id", int_id, exp_int[0].id);
                    chk("int_data", int_data, exp_int[0].data);
                    if (!int_stall) void'(exp_int.pop_front());
                end
            end
            if (pix_valid) begin
                if (exp_pix.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pix_unexpected: got pix_idx %0d with nothing expected", pix_idx);
                end else begin
                    chk("pix_idx", pix_idx, exp_pix.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_state = 0; m_init = 0; m_outst = 0; m_issued = 0; m_intv = 0; seq = 0; last_acc_id = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_int_valid", int_valid, 0);
        chk("rst_int_id", int_id, 0);
        chk("rst_int_data", int_data, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_idx", pix_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", prg_to_int_stall, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 16 INIT cycles, then the first accept gets ID 0.
        repeat (16) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("first_valid", int_valid, 1);
        chk("first_id", int_id, 0);
        repeat (15) cyc(1, 0, 0, 0, 0);
        chk("last_id", int_id, 15);
        repeat (4) cyc(1, 0, 0, 0, 0);
        chk("empty_stall", prg_to_int_stall, 1);

        // Retire ID 5 from the full state; it is reissued as pixel 16.
        cyc(1, 0, 0, 1, 5);
        chk("ret5_pix_valid", pix_valid, 1);
        chk("ret5_pix_idx", pix_idx, 5);
        cyc(1, 0, 0, 0, 0);
        chk("reuse_id", int_id, 5);

        // Free three IDs, then hold the output under int_stall.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 2);
        cyc(1, 0, 0, 0, 0);
        chk("hold_pre_id", int_id, 0);
        repeat (4) cyc(1, 1, 0, 0, 0);
        chk("hold_id", int_id, 0);
        chk("hold_valid", int_valid, 1);
        cyc(1, 0, 0, 0, 0);
        chk("resume_id", int_id, 1);
        cyc(1, 0, 0, 0, 0);
        chk("resume_id2", int_id, 2);

        // Finish the frame, retiring the oldest outstanding ray every other cycle.
        for (int k = 0; k < 400 && m_state != 3; k++) begin
            if (out_q.size() > 0 && (k % 2) == 0) cyc(1, 0, 0, 1, out_q[0]);
            else                                   cyc(1, 0, 0, 0, 0);
        end
        chk("frame_done_set", frame_done, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);

        // Restart: frame_done clears and the next ray is pixel 0.
        cyc(1, 0, 1, 0, 0);
        chk("start_clears_done", frame_done, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, last_acc_id);
        chk("restart_pix_idx", pix_idx, 0);

        // Second retire of the same ID is a protocol error.
        cyc(0, 0, 0, 1, last_acc_id);
        repeat (3) cyc(0, 0, 0, 0, 0);
`ifdef PRIM_RAY_DISPATCH_CHECK_EN
        chk("err_set", err, 1);
        repeat (2) cyc(0, 0, 0, 0, 0);
        chk("err_sticky", err, 1);
`else
        chk("err_tied", err, 0);
`endif
        chk("int_q_drained", exp_int.size(), 0);
        chk("pix_q_drained", exp_pix.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
